// File: rtl/tx_pkg.sv
// Shared definitions for the packet transmit path: FSM encoding, length field
// placement and the byte-length to word-count helper.
package tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR_WAIT,
      ST_BODY,
      ST_DRAIN
   } tx_state_t;

   localparam int unsigned LEN_WIDTH = 16;

   // Length field occupies the top LEN_WIDTH bits of the header word.
   function automatic int unsigned len_msb(input int unsigned dw);
      return dw - 1;
   endfunction

   function automatic int unsigned len_lsb(input int unsigned dw);
      return dw - LEN_WIDTH;
   endfunction

   // Words in a packet of len bytes; 17 bits so len = 0xFFFF cannot wrap.
   function automatic logic [16:0] words_of(input logic [15:0] len,
                                            input int unsigned w);
      logic [16:0] sum;
      sum = {1'b0, len} + 17'(w - 1);
      case (w)
         2:       return sum >> 1;
         4:       return sum >> 2;
         default: return sum >> 3;
      endcase
   endfunction

endpackage

// File: rtl/tx_skid_buffer.sv
// Two-entry FIFO of output words with their framing tags (sop, eop, mod).
// Head outputs are only meaningful while o_count is non-zero.
module tx_skid_buffer #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned MOD_WIDTH  = 8
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_sop,
   input  logic                  i_eop,
   input  logic [MOD_WIDTH-1:0]  i_mod,
   input  logic                  i_pop,
   output logic [1:0]            o_count,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_sop,
   output logic                  o_eop,
   output logic [MOD_WIDTH-1:0]  o_mod
);

   localparam int unsigned ENTRY_W = DATA_WIDTH + MOD_WIDTH + 2;

   logic [ENTRY_W-1:0] r_mem [2];
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [1:0]         r_count;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= ~r_wr_ptr;
         if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   always_ff @(posedge Clk) begin
      if (i_push) r_mem[r_wr_ptr] <= {i_data, i_sop, i_eop, i_mod};
   end

   assign {o_data, o_sop, o_eop, o_mod} = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/transmit_packet.sv
// Pops length-prefixed packets from a one-cycle-latency FIFO and frames them
// onto OutBus with Val/Sop/Eop/Mod, honouring OutBus_Rdy backpressure.
module transmit_packet
   import tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    fifo_empty,
   output logic                    fifo_rd,
   input  logic [DATA_WIDTH-1:0]   fifo_data_in,
   input  logic                    OutBus_Rdy,
   output logic                    OutBus_Val,
   output logic                    OutBus_Sop,
   output logic                    OutBus_Eop,
   output logic [DATA_WIDTH/8-1:0] OutBus_Mod,
   output logic [DATA_WIDTH-1:0]   OutBus_Dat,
   output logic                    OutBus_Error,
   output logic                    tx_busy
);

   localparam int unsigned W       = DATA_WIDTH / 8;
   localparam int unsigned MOD_B   = $clog2(W);
   localparam int unsigned LEN_MSB = len_msb(DATA_WIDTH);
   localparam int unsigned LEN_LSB = len_lsb(DATA_WIDTH);

   tx_state_t       r_state;
   tx_state_t       w_next_state;

   logic [15:0]     r_words_left;
   logic [W-1:0]    r_last_mod;
   logic            r_rd_pend;
   logic            r_rd_last;
   logic            r_error;

   logic [15:0]     w_len;
   logic [16:0]     w_words;
   logic            w_len_bad;
   logic            w_hdr_only;
   logic [W-1:0]    w_hdr_mod;

   logic            w_hdr_rd;
   logic            w_body_rd;
   logic            w_hdr_push;
   logic            w_out_val;
   logic            w_xfer;
   logic [2:0]      w_held;

   logic            w_buf_push;
   logic            w_buf_pop;
   logic [DATA_WIDTH-1:0] w_push_data;
   logic            w_push_sop;
   logic            w_push_eop;
   logic [W-1:0]    w_push_mod;

   logic [1:0]      w_buf_count;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic            w_head_sop;
   logic            w_head_eop;
   logic [W-1:0]    w_head_mod;

   assign w_len      = fifo_data_in[LEN_MSB:LEN_LSB];
   assign w_words    = words_of(w_len, W);
   assign w_len_bad  = w_len < 16'(W);
   assign w_hdr_only = (w_words == 17'd1);
   assign w_hdr_mod  = W'(w_len[MOD_B-1:0]);

   // Val depends only on registered state, never on OutBus_Rdy.
   assign w_out_val = (w_buf_count != 2'd0) || r_rd_pend;
   assign w_xfer    = w_out_val && OutBus_Rdy;
   assign w_held    = {1'b0, w_buf_count} + {2'b00, r_rd_pend};
   assign w_buf_pop = w_xfer && (w_buf_count != 2'd0);

   always_ff @(posedge Clk) begin
      if (Rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!fifo_empty) w_next_state = ST_HDR_WAIT;
         end
         ST_HDR_WAIT: begin
            if (w_len_bad)       w_next_state = ST_IDLE;
            else if (w_hdr_only) w_next_state = ST_DRAIN;
            else                 w_next_state = ST_BODY;
         end
         ST_BODY: begin
            if (w_body_rd && (r_words_left == 16'd1)) w_next_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_xfer && OutBus_Eop) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Body reads are credit-limited: words held (buffered or in flight) minus
   // the one leaving this cycle must stay below the two buffer entries.
   always_comb begin
      w_hdr_rd   = 1'b0;
      w_body_rd  = 1'b0;
      w_hdr_push = 1'b0;
      case (r_state)
         ST_IDLE:     w_hdr_rd   = !fifo_empty;
         ST_HDR_WAIT: w_hdr_push = !w_len_bad;
         ST_BODY:     w_body_rd  = !fifo_empty &&
                                   ((w_held - {2'b00, w_xfer}) < 3'd2);
         default:     ;
      endcase
      fifo_rd = !Rst && (w_hdr_rd || w_body_rd);
      tx_busy = !Rst && ((r_state != ST_IDLE) || w_hdr_rd);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_words_left <= '0;
         r_last_mod   <= '0;
         r_rd_pend    <= 1'b0;
         r_rd_last    <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_error   <= (r_state == ST_HDR_WAIT) && w_len_bad;
         r_rd_pend <= w_body_rd;
         if (w_body_rd) r_rd_last <= (r_words_left == 16'd1);
         if (w_hdr_push) begin
            r_words_left <= 16'(w_words - 17'd1);
            r_last_mod   <= w_hdr_mod;
         end else if (w_body_rd) begin
            r_words_left <= r_words_left - 16'd1;
         end
      end
   end

   // Arriving body word bypasses the buffer when it is empty and the word is
   // accepted in its arrival cycle; otherwise it is parked behind the head.
   always_comb begin
      w_buf_push  = 1'b0;
      w_push_data = fifo_data_in;
      w_push_sop  = 1'b0;
      w_push_eop  = 1'b0;
      w_push_mod  = '0;
      if (w_hdr_push) begin
         w_buf_push = 1'b1;
         w_push_sop = 1'b1;
         w_push_eop = w_hdr_only;
         w_push_mod = w_hdr_only ? w_hdr_mod : '0;
      end else if (r_rd_pend) begin
         w_buf_push = !((w_buf_count == 2'd0) && w_xfer);
         w_push_eop = r_rd_last;
         w_push_mod = r_rd_last ? r_last_mod : '0;
      end
   end

   tx_skid_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .MOD_WIDTH  (W)
   ) u_skid (
      .Clk     (Clk),
      .Rst     (Rst),
      .i_push  (w_buf_push),
      .i_data  (w_push_data),
      .i_sop   (w_push_sop),
      .i_eop   (w_push_eop),
      .i_mod   (w_push_mod),
      .i_pop   (w_buf_pop),
      .o_count (w_buf_count),
      .o_data  (w_head_data),
      .o_sop   (w_head_sop),
      .o_eop   (w_head_eop),
      .o_mod   (w_head_mod)
   );

   always_comb begin
      OutBus_Val = w_out_val;
      OutBus_Dat = '0;
      OutBus_Sop = 1'b0;
      OutBus_Eop = 1'b0;
      OutBus_Mod = '0;
      if (w_buf_count != 2'd0) begin
         OutBus_Dat = w_head_data;
         OutBus_Sop = w_head_sop;
         OutBus_Eop = w_head_eop;
         OutBus_Mod = w_head_mod;
      end else if (r_rd_pend) begin
         OutBus_Dat = w_push_data;
         OutBus_Sop = w_push_sop;
         OutBus_Eop = w_push_eop;
         OutBus_Mod = w_push_mod;
      end
   end

   assign OutBus_Error = r_error;

endmodule

// File: tb/tb_transmit_packet.sv
// Self-checking bench for transmit_packet: a queue-based source FIFO and an
// expected-beat scoreboard built from packet lengths.
module tb_transmit_packet;

   localparam int unsigned DW = 64;
   localparam int unsigned W  = 8;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          fifo_empty;
   logic          fifo_rd;
   logic [DW-1:0] fifo_data_in;
   logic          OutBus_Rdy;
   logic          OutBus_Val;
   logic          OutBus_Sop;
   logic          OutBus_Eop;
   logic [W-1:0]  OutBus_Mod;
   logic [DW-1:0] OutBus_Dat;
   logic          OutBus_Error;
   logic          tx_busy;

   always #5 Clk = ~Clk;

   transmit_packet #(.DATA_WIDTH(DW)) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .fifo_empty   (fifo_empty),
      .fifo_rd      (fifo_rd),
      .fifo_data_in (fifo_data_in),
      .OutBus_Rdy   (OutBus_Rdy),
      .OutBus_Val   (OutBus_Val),
      .OutBus_Sop   (OutBus_Sop),
      .OutBus_Eop   (OutBus_Eop),
      .OutBus_Mod   (OutBus_Mod),
      .OutBus_Dat   (OutBus_Dat),
      .OutBus_Error (OutBus_Error),
      .tx_busy      (tx_busy)
   );

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [63:0]  src_q[$];
   logic [63:0]  held_q[$];
   logic [73:0]  exp_q[$];
   bit           rdy_pat[$];
   int           exp_err = 0;
   int           obs_err = 0;
   bit           rnd_mode = 1'b0;
   int           starve = 0;
   int           cyc = 0;
   int           rd_cnt = 0;
   int           first_rd = -1;
   int           sop_cyc[$];
   int           eop_cyc[$];
   int           outst = 0;
   logic         prev_stall = 1'b0;
   logic [73:0]  prev_beat = '0;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_meas();
      rd_cnt   = 0;
      first_rd = -1;
      sop_cyc.delete();
      eop_cyc.delete();
   endtask

   // Builds one packet; the first nnow words go to the FIFO, the rest wait.
   task automatic push_packet(input logic [15:0] len, input int nnow);
      logic [63:0] w;
      int          nw;
      if (len < 16'(W)) begin
         nw = 1;
         exp_err++;
      end else begin
         nw = (int'(len) + int'(W) - 1) / int'(W);
      end
      for (int i = 0; i < nw; i++) begin
         w = {$urandom, $urandom};
         if (i == 0) w[63:48] = len;
         if (len >= 16'(W))
            exp_q.push_back({w, (i == 0), (i == nw - 1),
                             (i == nw - 1) ? 8'(len % 16'(W)) : 8'h00});
         if (nnow < 0 || i < nnow) src_q.push_back(w);
         else                      held_q.push_back(w);
      end
   endtask

   // Entered and left at posedge+1; samples outputs at posedge+2.
   task automatic tick();
      logic        rd_now;
      logic        xfer;
      logic [73:0] beat;
      fifo_empty = (src_q.size() == 0) || (starve > 0);
      if (rdy_pat.size() > 0) OutBus_Rdy = rdy_pat.pop_front();
      else                    OutBus_Rdy = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      rd_now = fifo_rd;
      beat   = {OutBus_Dat, OutBus_Sop, OutBus_Eop, OutBus_Mod};
      xfer   = OutBus_Val && OutBus_Rdy;
      if (prev_stall) chk("stall_hold", 80'({OutBus_Val, beat}), 80'({1'b1, prev_beat}));
      if (xfer) begin
         if (exp_q.size() == 0) chk("beat_extra", 80'(1), 80'(0));
         else                   chk("beat", 80'(beat), 80'(exp_q.pop_front()));
         if (OutBus_Sop) sop_cyc.push_back(cyc);
         if (OutBus_Eop) eop_cyc.push_back(cyc);
      end
      if (OutBus_Error) obs_err++;
      outst += int'(rd_now) - int'(xfer) - int'(OutBus_Error);
      if (rd_now) begin
         rd_cnt++;
         if (first_rd < 0) first_rd = cyc;
         chk("rd_on_empty", 80'(fifo_empty), 80'(0));
         chk("rd_credit", 80'(outst <= 2), 80'(1));
      end
      prev_stall = OutBus_Val && !OutBus_Rdy;
      prev_beat  = beat;
      @(posedge Clk);
      #1;
      cyc++;
      if (starve > 0) starve--;
      if (rnd_mode && starve == 0 && $urandom_range(0, 15) == 0) starve = $urandom_range(1, 4);
      if (rd_now && src_q.size() > 0) fifo_data_in = src_q.pop_front();
   endtask

   task automatic run_idle(input string tag);
      int n;
      n = 0;
      while ((src_q.size() > 0 || exp_q.size() > 0 || tx_busy || OutBus_Val) && n < 3000) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 80'(n < 3000), 80'(1));
      repeat (3) tick();
   endtask

   task automatic chk_reset_outs(input string tag);
      chk(tag, 80'({OutBus_Val, OutBus_Sop, OutBus_Eop, OutBus_Error, fifo_rd, tx_busy,
                    OutBus_Mod, OutBus_Dat}), 80'(0));
   endtask

   initial begin
      int          err0;
      logic [15:0] len;
      Rst          = 1'b1;
      fifo_empty   = 1'b1;
      fifo_data_in = '0;
      OutBus_Rdy   = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      chk_reset_outs("reset_out");
      Rst = 1'b0;

      // Three-word packet, full rate
      clear_meas();
      push_packet(16'h0018, -1);
      run_idle("p24");
      chk("hdr_latency", 80'(sop_cyc[0] - first_rd), 80'(2));
      chk("eop_after_sop", 80'(eop_cyc[0] - sop_cyc[0]), 80'(2));
      chk("rd_pulses", 80'(rd_cnt), 80'(3));

      // Partial last word
      clear_meas();
      push_packet(16'h0014, -1);
      run_idle("p20");
      chk("p20_rd", 80'(rd_cnt), 80'(3));

      // Single-word packet then back-to-back packet: two idle cycles between
      clear_meas();
      push_packet(16'h0008, -1);
      push_packet(16'h0010, -1);
      run_idle("p8");
      chk("single_sop_eop", 80'(eop_cyc[0] - sop_cyc[0]), 80'(0));
      chk("pkt_gap", 80'(sop_cyc[1] - eop_cyc[0]), 80'(3));

      // Illegal length drops header and raises one error pulse
      clear_meas();
      err0 = obs_err;
      push_packet(16'h0005, -1);
      push_packet(16'h0010, -1);
      run_idle("bad");
      chk("bad_err_pulse", 80'(obs_err - err0), 80'(1));
      chk("bad_rd", 80'(rd_cnt), 80'(3));

      // Backpressure pattern once the header is presented
      clear_meas();
      rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      push_packet(16'h0020, -1);
      run_idle("stall");
      chk("stall_rd", 80'(rd_cnt), 80'(4));
      chk("stall_eops", 80'(eop_cyc.size()), 80'(1));

      // Source runs dry mid-packet
      clear_meas();
      push_packet(16'h0020, 2);
      repeat (8) tick();
      chk("gap_val", 80'(OutBus_Val), 80'(0));
      chk("gap_busy", 80'(tx_busy), 80'(1));
      while (held_q.size() > 0) src_q.push_back(held_q.pop_front());
      run_idle("gap");
      chk("gap_eops", 80'(eop_cyc.size()), 80'(1));

      // Randomised packets, backpressure and source starvation
      rnd_mode = 1'b1;
      for (int p = 0; p < 40; p++) begin
         if ($urandom_range(0, 4) == 0) len = 16'($urandom_range(0, 7));
         else                           len = 16'($urandom_range(8, 120));
         push_packet(len, -1);
         repeat ($urandom_range(0, 5)) tick();
      end
      run_idle("rnd");
      rnd_mode = 1'b0;
      starve   = 0;

      // Reset in the middle of a packet
      push_packet(16'h0040, -1);
      repeat (5) tick();
      Rst = 1'b1;
      tick();
      #1;
      chk_reset_outs("midrst_out");
      src_q.delete();
      held_q.delete();
      exp_q.delete();
      fifo_data_in = '0;
      outst        = 0;
      prev_stall   = 1'b0;
      Rst          = 1'b0;
      clear_meas();
      push_packet(16'h0010, -1);
      run_idle("post_rst");
      chk("post_rst_rd", 80'(rd_cnt), 80'(2));

      chk("err_total", 80'(obs_err), 80'(exp_err));
      chk("exp_drained", 80'(exp_q.size()), 80'(0));
      chk("idle_busy", 80'(tx_busy), 80'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
